rv_mc_ctrl: RTL

Parametrised multicycle control unit for the RV32 datapath. It sequences the shared-databus enables, register-file controls and ALU function for fetch, R-type, I-type ALU, LW, SW and JALR. Unlike the fixed-latency controller, it talks to memory through a req/ack handshake, so RAM may insert wait states. It also detects illegal encodings and optionally traps on memory timeout. It sits between the instruction register (IR) and datapath on one side and the RAM port on the other.

---
 rtl/rv_mc_ctrl_if.sv | 36 +++
 rtl/rv_mc_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mc_ctrl_if.sv
// rtl/rv_mc_ctrl_if.sv - IR/datapath/RAM signal bundle for the multicycle controller.
// master = controller side, slave = datapath and RAM side.
interface rv_mc_ctrl_if #(
  parameter int RA_W = 5
);
  logic [31:0]     instr;
  logic            mem_ack;
  logic            mem_req;
  logic            mem_we;
  logic            pc_bus_en;
  logic            alu_bus_en;
  logic            imm_bus_en;
  logic            rf_bus_en;
  logic            rd_bus_en;
  logic            pc_en;
  logic            pc_inc;
  logic            a_en;
  logic            b_en;
  logic            ir_en;
  logic            rf_wen;
  logic            rf_ren;
  logic [RA_W-1:0] rf_addr;
  logic [3:0]      alu_func;

  modport master (
    input  instr, mem_ack,
    output mem_req, mem_we, pc_bus_en, alu_bus_en, imm_bus_en, rf_bus_en, rd_bus_en,
           pc_en, pc_inc, a_en, b_en, ir_en, rf_wen, rf_ren, rf_addr, alu_func
  );

  modport slave (
    output instr, mem_ack,
    input  mem_req, mem_we, pc_bus_en, alu_bus_en, imm_bus_en, rf_bus_en, rd_bus_en,
           pc_en, pc_inc, a_en, b_en, ir_en, rf_wen, rf_ren, rf_addr, alu_func
  );
endinterface

// File: rtl/rv_mc_ctrl.sv
// rtl/rv_mc_ctrl.sv - RV32 multicycle control unit with req/ack memory handshake.
// Define RV_MC_CTRL_TIMEOUT_EN to add the memory wait counter and timeout trap.
module rv_mc_ctrl #(
  parameter int RA_W        = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  rv_mc_ctrl_if.master bus,
  output logic         trap,
  output logic [4:0]   state_dbg
);

  typedef enum logic [4:0] {
    S_INIT = 5'd0, S_F0, S_F1, S_F2, S_DEC,
    S_A1, S_A2, S_I1, S_I2,
    S_L1, S_L2, S_L3, S_S1, S_S2, S_S3,
    S_J1, S_J2, S_J3, S_TRAP
  } state_t;

  state_t state_q, state_d;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd_idx, rs1_idx, rs2_idx;
  logic [RA_W-1:0] rd_a, rs1_a, rs2_a;
  logic            rd_nz;

  assign opcode  = bus.instr[6:0];
  assign rd_idx  = bus.instr[11:7];
  assign funct3  = bus.instr[14:12];
  assign rs1_idx = bus.instr[19:15];
  assign rs2_idx = bus.instr[24:20];
  assign funct7  = bus.instr[31:25];
  assign rd_a    = bus.instr[7 +: RA_W];
  assign rs1_a   = bus.instr[15 +: RA_W];
  assign rs2_a   = bus.instr[20 +: RA_W];
  assign rd_nz   = (rd_idx != 5'd0);

  // An index fits when no bit above RA_W is set; always true for RA_W = 5.
  function automatic logic fits(input logic [4:0] idx);
    return (idx >> RA_W) == 5'd0;
  endfunction

  state_t dispatch;
  logic   illegal;

  always_comb begin
    dispatch = S_TRAP;
    illegal  = 1'b1;
    case (opcode)
      7'b0110011: begin
        dispatch = S_A1;
        illegal  = !((funct7 == 7'b0000000) ||
                     (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) ||
                   !fits(rd_idx) || !fits(rs1_idx) || !fits(rs2_idx);
      end
      7'b0010011: begin
        dispatch = S_I1;
        illegal  = !fits(rd_idx) || !fits(rs1_idx);
      end
      7'b0000011: begin
        dispatch = S_L1;
        illegal  = (funct3 != 3'b010) || !fits(rd_idx) || !fits(rs1_idx);
      end
      7'b0100011: begin
        dispatch = S_S1;
        illegal  = (funct3 != 3'b010) || !fits(rs1_idx) || !fits(rs2_idx);
      end
      7'b1100111: begin
        dispatch = S_J1;
        illegal  = (funct3 != 3'b000) || !fits(rd_idx) || !fits(rs1_idx);
      end
      default: begin
        dispatch = S_TRAP;
        illegal  = 1'b1;
      end
    endcase
  end

  logic timeout;

`ifdef RV_MC_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          in_wait;

  assign in_wait = (state_q == S_F1) || (state_q == S_L3) || (state_q == S_S3);

  // Held at zero outside wait states, so each wait state starts from zero.
  always_comb begin
    wcnt_d  = '0;
    timeout = 1'b0;
    if (in_wait && !bus.mem_ack) begin
      wcnt_d  = wcnt_q + 1'b1;
      timeout = (wcnt_q == CW'(MEM_TIMEOUT - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) wcnt_q <= '0;
    else     wcnt_q <= wcnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.pc_bus_en  = 1'b0;
    bus.alu_bus_en = 1'b0;
    bus.imm_bus_en = 1'b0;
    bus.rf_bus_en  = 1'b0;
    bus.rd_bus_en  = 1'b0;
    bus.pc_en      = 1'b0;
    bus.pc_inc     = 1'b0;
    bus.a_en       = 1'b0;
    bus.b_en       = 1'b0;
    bus.ir_en      = 1'b0;
    bus.rf_wen     = 1'b0;
    bus.rf_ren     = 1'b0;
    bus.rf_addr    = '0;
    bus.alu_func   = 4'b0000;
    trap           = 1'b0;
    unique case (state_q)
      S_INIT: state_d = S_F0;
      S_F0: begin
        bus.pc_bus_en = 1'b1;
        bus.mem_req   = 1'b1;
        state_d       = S_F1;
      end
      S_F1: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) begin
          bus.rd_bus_en = 1'b1;
          bus.ir_en     = 1'b1;
          state_d       = S_F2;
        end else if (timeout) begin
          state_d = S_TRAP;
        end
      end
      S_F2: begin
        bus.pc_inc = 1'b1;
        state_d    = S_DEC;
      end
      S_DEC: begin
        bus.rf_addr   = rs1_a;
        bus.rf_ren    = 1'b1;
        bus.rf_bus_en = 1'b1;
        bus.a_en      = 1'b1;
        state_d       = illegal ? S_TRAP : dispatch;
      end
      S_A1: begin
        bus.rf_addr   = rs2_a;
        bus.rf_bus_en = 1'b1;
        bus.b_en      = 1'b1;
        state_d       = S_A2;
      end
      S_A2: begin
        bus.alu_bus_en = 1'b1;
        bus.alu_func   = {bus.instr[30], funct3};
        bus.rf_addr    = rd_a;
        bus.rf_wen     = rd_nz;
        state_d        = S_F0;
      end
      S_I1, S_L1, S_S1, S_J2: begin
        bus.imm_bus_en = 1'b1;
        bus.b_en       = 1'b1;
        unique case (state_q)
          S_I1:    state_d = S_I2;
          S_L1:    state_d = S_L2;
          S_S1:    state_d = S_S2;
          default: state_d = S_J3;
        endcase
      end
      S_I2: begin
        // Only the shift-right immediate carries an alt bit; elsewhere bit 30 is immediate data.
        bus.alu_bus_en = 1'b1;
        bus.alu_func   = {(funct3 == 3'b101) & bus.instr[30], funct3};
        bus.rf_addr    = rd_a;
        bus.rf_wen     = rd_nz;
        state_d        = S_F0;
      end
      S_L2: begin
        bus.alu_bus_en = 1'b1;
        bus.mem_req    = 1'b1;
        state_d        = S_L3;
      end
      S_L3: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) begin
          bus.rd_bus_en = 1'b1;
          bus.rf_addr   = rd_a;
          bus.rf_wen    = rd_nz;
          state_d       = S_F0;
        end else if (timeout) begin
          state_d = S_TRAP;
        end
      end
      S_S2: begin
        bus.alu_bus_en = 1'b1;
        bus.mem_req    = 1'b1;
        bus.mem_we     = 1'b1;
        state_d        = S_S3;
      end
      S_S3: begin
        bus.rf_addr   = rs2_a;
        bus.rf_bus_en = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        if (bus.mem_ack)  state_d = S_F0;
        else if (timeout) state_d = S_TRAP;
      end
      S_J1: begin
        bus.pc_bus_en = 1'b1;
        bus.rf_addr   = rd_a;
        bus.rf_wen    = rd_nz;
        state_d       = S_J2;
      end
      S_J3: begin
        bus.alu_bus_en = 1'b1;
        bus.pc_en      = 1'b1;
        state_d        = S_F0;
      end
      S_TRAP:  trap = 1'b1;
      default: state_d = S_TRAP;
    endcase
  end

  assign state_dbg = state_q;

endmodule
